// File: rtl/mp_types.sv
// Shared mixed-precision types and helpers for the matrix datapath.
// fmt_lane is the single source of truth for per-lane operand formatting.
package mp_types;

    localparam int LANE_W = 32;

    typedef enum logic [1:0] {
        PREC_INT8 = 2'd0,
        PREC_FP16 = 2'd1,
        PREC_BF16 = 2'd2,
        PREC_FP32 = 2'd3
    } prec_e;

    function automatic logic [LANE_W-1:0] fmt_lane(
        input prec_e             prec,
        input logic [LANE_W-1:0] x
    );
        logic [LANE_W-1:0] y;
        y = x;
        if (prec == PREC_INT8) begin
            y = {{(LANE_W-8){x[7]}}, x[7:0]};
        end
        return y;
    endfunction

endpackage

// File: rtl/systolic_feeder_bank.sv
// feeder_bank: KMAX-deep operand register file, one write port and one
// synchronous read port whose data register resets to zero and holds.
module feeder_bank #(
    parameter int KMAX = 16,
    parameter int W    = 256
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    wr_en,
    input  logic [$clog2(KMAX)-1:0] wr_addr,
    input  logic [W-1:0]            wr_data,
    input  logic                    rd_en,
    input  logic [$clog2(KMAX)-1:0] rd_addr,
    output logic [W-1:0]            rd_data
);

    logic [W-1:0] mem_q [KMAX];
    logic [W-1:0] rd_q;
    logic [W-1:0] rd_d;

    // Storage array; contents are intentionally left unreset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // Read data holds its last value when no read is requested.
    always_comb begin
        rd_d = rd_q;
        if (rd_en) begin
            rd_d = mem_q[rd_addr];
        end
    end

    // Read register; a same-cycle write is seen only on the next read.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_q <= '0;
        end else begin
            rd_q <= rd_d;
        end
    end

    assign rd_data = rd_q;

endmodule

// File: rtl/systolic_feeder.sv
// systolic_feeder: streams one operand tile to the systolic array.
// Define FEEDER_PINGPONG_EN for a double-buffered (load-while-stream) build.
module systolic_feeder
    import mp_types::*;
#(
    parameter int    N    = 4,
    parameter int    KMAX = 16,
    parameter prec_e PREC = PREC_INT8
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    wr_en,
    output logic                    wr_rdy,
    input  logic [$clog2(KMAX)-1:0] wr_addr,
    input  logic [N*32-1:0]         wr_a,
    input  logic [N*32-1:0]         wr_b,
    input  logic                    start,
    input  logic [$clog2(KMAX):0]   k_len,
    output logic                    busy,
    output logic                    done,
    output logic                    valid,
    output logic                    first,
    output logic [N*32-1:0]         a_row,
    output logic [N*32-1:0]         b_col
);

    localparam int AW = $clog2(KMAX);
    localparam int KW = AW + 1;
    localparam int DW = 2 * N * 32;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_STREAM = 2'd1;
    localparam logic [1:0] S_FINISH = 2'd2;

    localparam logic [KW-1:0] KMAX_K = KW'(KMAX);

    logic [1:0]    state_q, state_d;
    logic [KW-1:0] k_q, k_d;
    logic [KW-1:0] len_q, len_d;
    logic [KW-1:0] len_c;
    logic          busy_q, busy_d;
    logic          valid_q, valid_d;
    logic          first_q, first_d;
    logic          done_q, done_d;
    logic          accept;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic          wr_ok;
    logic [DW-1:0] rd_data;

    assign len_c = (k_len > KMAX_K) ? KMAX_K : k_len;
    assign wr_ok = wr_en && wr_rdy && (32'(wr_addr) < KMAX);

    // Sequencer: k_q counts beats already issued in the current tile.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        len_d   = len_q;
        busy_d  = busy_q;
        valid_d = 1'b0;
        first_d = 1'b0;
        done_d  = 1'b0;
        accept  = 1'b0;
        rd_en   = 1'b0;
        rd_addr = k_q[AW-1:0];
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    accept = 1'b1;
                    if (len_c == '0) begin
                        state_d = S_FINISH;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_STREAM;
                        len_d   = len_c;
                        k_d     = KW'(1);
                        busy_d  = 1'b1;
                        valid_d = 1'b1;
                        first_d = 1'b1;
                        rd_en   = 1'b1;
                        rd_addr = '0;
                    end
                end
            end
            S_STREAM: begin
                if (k_q == len_q) begin
                    state_d = S_FINISH;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    k_d     = k_q + KW'(1);
                    valid_d = 1'b1;
                    rd_en   = 1'b1;
                end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Control and strobe registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            len_q   <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            first_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            len_q   <= len_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
            first_q <= first_d;
            done_q  <= done_d;
        end
    end

`ifdef FEEDER_PINGPONG_EN
    logic          act_q, act_d;
    logic          sel_q, sel_d;
    logic [DW-1:0] rd0, rd1;

    // act_d names the bank read this cycle; the other one takes writes,
    // so a write beside an accepted start lands in the outgoing bank.
    always_comb begin
        act_d = accept ? ~act_q : act_q;
        sel_d = rd_en ? act_d : sel_q;
    end

    // Active-bank pointer and output-side bank select.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            act_q <= 1'b0;
            sel_q <= 1'b0;
        end else begin
            act_q <= act_d;
            sel_q <= sel_d;
        end
    end

    feeder_bank #(.KMAX(KMAX), .W(DW)) u_bank0 (
        .clk     (clk),
        .rstn    (rstn),
        .wr_en   (wr_ok && act_d),
        .wr_addr (wr_addr),
        .wr_data ({wr_b, wr_a}),
        .rd_en   (rd_en && !act_d),
        .rd_addr (rd_addr),
        .rd_data (rd0)
    );

    feeder_bank #(.KMAX(KMAX), .W(DW)) u_bank1 (
        .clk     (clk),
        .rstn    (rstn),
        .wr_en   (wr_ok && !act_d),
        .wr_addr (wr_addr),
        .wr_data ({wr_b, wr_a}),
        .rd_en   (rd_en && act_d),
        .rd_addr (rd_addr),
        .rd_data (rd1)
    );

    assign rd_data = sel_q ? rd1 : rd0;
    assign wr_rdy  = 1'b1;
`else
    feeder_bank #(.KMAX(KMAX), .W(DW)) u_bank (
        .clk     (clk),
        .rstn    (rstn),
        .wr_en   (wr_ok),
        .wr_addr (wr_addr),
        .wr_data ({wr_b, wr_a}),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    assign wr_rdy = !busy_q;
`endif

    for (genvar j = 0; j < N; j++) begin : g_lane
        assign a_row[j*32 +: 32] = fmt_lane(PREC, rd_data[j*32 +: 32]);
        assign b_col[j*32 +: 32] = fmt_lane(PREC, rd_data[N*32 + j*32 +: 32]);
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign valid = valid_q;
    assign first = first_q;

endmodule

// File: tb/tb_systolic_feeder.sv
// Directed + randomized bench for systolic_feeder against a tile-level
// model (banks as arrays, beats derived from the streaming rules).
module tb_systolic_feeder;
    import mp_types::*;

    localparam int N    = 4;
    localparam int KMAX = 16;
    localparam int AW   = 4;
    localparam int KW   = 5;
    localparam int DW   = N * 32;
`ifdef FEEDER_PINGPONG_EN
    localparam bit PP = 1'b1;
`else
    localparam bit PP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rstn;
    logic          wr_en;
    logic          wr_rdy;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_a;
    logic [DW-1:0] wr_b;
    logic          start;
    logic [KW-1:0] k_len;
    logic          busy;
    logic          done;
    logic          valid;
    logic          first;
    logic [DW-1:0] a_row;
    logic [DW-1:0] b_col;

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] ma [2][KMAX];
    logic [DW-1:0] mb [2][KMAX];
    bit            act = 1'b0;
    logic [DW-1:0] last_a = '0;
    logic [DW-1:0] last_b = '0;

    systolic_feeder #(.N(N), .KMAX(KMAX), .PREC(PREC_INT8)) dut (
        .clk     (clk),
        .rstn    (rstn),
        .wr_en   (wr_en),
        .wr_rdy  (wr_rdy),
        .wr_addr (wr_addr),
        .wr_a    (wr_a),
        .wr_b    (wr_b),
        .start   (start),
        .k_len   (k_len),
        .busy    (busy),
        .done    (done),
        .valid   (valid),
        .first   (first),
        .a_row   (a_row),
        .b_col   (b_col)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [DW-1:0] obs,
                       input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] fmt_row(input logic [DW-1:0] x);
        logic [DW-1:0] y;
        for (int j = 0; j < N; j++) begin
            y[j*32 +: 32] = 32'($signed(x[j*32 +: 8]));
        end
        return y;
    endfunction

    task automatic wr(input int addr, input logic [DW-1:0] a,
                      input logic [DW-1:0] b);
        bit wb;
        wb      = PP ? !act : 1'b0;
        wr_en   = 1'b1;
        wr_addr = AW'(addr);
        wr_a    = a;
        wr_b    = b;
        ma[wb][addr] = a;
        mb[wb][addr] = b;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic load_rand(input int n);
        for (int k = 0; k < n; k++) begin
            wr(k, {$urandom(), $urandom(), $urandom(), $urandom()},
                  {$urandom(), $urandom(), $urandom(), $urandom()});
        end
    endtask

    task automatic run_tile(input int L, input bit poke,
                            input bit stream_wr, input logic [31:0] wv);
        int            le;
        bit            rb;
        logic [DW-1:0] ea [KMAX];
        logic [DW-1:0] eb [KMAX];
        le = (L > KMAX) ? KMAX : L;
        if (PP) act = !act;
        rb = PP ? act : 1'b0;
        for (int k = 0; k < le; k++) begin
            ea[k] = fmt_row(ma[rb][k]);
            eb[k] = fmt_row(mb[rb][k]);
        end
        start = 1'b1;
        k_len = KW'(L);
        tick();
        start = 1'b0;
        for (int b = 0; b < le; b++) begin
            chk("beat_valid", valid, 1);
            chk("beat_first", first, (b == 0));
            chk("beat_a_row", a_row, ea[b]);
            chk("beat_b_col", b_col, eb[b]);
            chk("beat_busy", busy, 1);
            chk("beat_done", done, 0);
            chk("beat_wr_rdy", wr_rdy, PP);
            wr_en = stream_wr;
            wr_addr = AW'(b);
            wr_a = {N{wv}};
            wr_b = {N{wv}};
            if (stream_wr && PP) begin
                ma[!act][b] = {N{wv}};
                mb[!act][b] = {N{wv}};
            end
            start = poke && (b == 1);
            k_len = KW'($urandom_range(1, 8));
            tick();
        end
        wr_en = 1'b0;
        start = 1'b0;
        if (le > 0) begin
            last_a = ea[le-1];
            last_b = eb[le-1];
        end
        chk("fin_done", done, 1);
        chk("fin_valid", valid, 0);
        chk("fin_busy", busy, 0);
        chk("fin_first", first, 0);
        chk("fin_hold_a", a_row, last_a);
        chk("fin_hold_b", b_col, last_b);
        start = poke;
        k_len = KW'(3);
        tick();
        start = 1'b0;
        chk("post_done", done, 0);
        chk("post_valid", valid, 0);
        chk("post_busy", busy, 0);
    endtask

    initial begin
        int L;
        rstn    = 1'b0;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_a    = '0;
        wr_b    = '0;
        start   = 1'b0;
        k_len   = '0;
        #1;
        chk("rst_valid", valid, 0);
        chk("rst_first", first, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_a_row", a_row, 0);
        chk("rst_b_col", b_col, 0);
        chk("rst_wr_rdy", wr_rdy, 1);
        tick();
        tick();
        rstn = 1'b1;
        tick();

        // INT8 sign-extension tile: 0x80..0x83 -> 0xFFFFFF80..0xFFFFFF83
        for (int k = 0; k < 4; k++) begin
            wr(k, {N{32'h80 + 32'(k)}}, {N{32'h01}});
        end
        run_tile(4, 1'b0, 1'b0, 32'h0);
        chk("int8_last_lane", a_row[31:0], 32'hFFFFFF83);

        // zero-length tile
        run_tile(0, 1'b0, 1'b0, 32'h0);

        // randomized tiles, with ignored starts mid-stream and in done
        for (int r = 0; r < 4; r++) begin
            L = $urandom_range(1, KMAX);
            load_rand(L);
            run_tile(L, r[0], 1'b0, 32'h0);
        end

        // over-long tile is clamped
        load_rand(KMAX);
        run_tile(20, 1'b1, 1'b0, 32'h0);

        // reset in the middle of an 8-beat tile
        load_rand(8);
        if (PP) act = !act;
        start = 1'b1;
        k_len = KW'(8);
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("mid_pre_valid", valid, 1);
        rstn = 1'b0;
        #1;
        chk("mid_valid", valid, 0);
        chk("mid_busy", busy, 0);
        chk("mid_first", first, 0);
        chk("mid_done", done, 0);
        chk("mid_a_row", a_row, 0);
        act    = 1'b0;
        last_a = '0;
        last_b = '0;
        tick();
        tick();
        rstn = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("mid_no_done", done, 0);
            chk("mid_no_valid", valid, 0);
        end
        load_rand(3);
        run_tile(3, 1'b0, 1'b0, 32'h0);

        // load during stream: double buffer accepts, single bank drops
        for (int k = 0; k < 4; k++) begin
            wr(k, {N{32'h11}}, {N{32'h11}});
        end
        run_tile(4, 1'b0, 1'b1, 32'h55);
        run_tile(4, 1'b0, 1'b0, 32'h0);
        chk("pp_lane0", a_row[31:0], PP ? 32'h55 : 32'h11);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
